// File: rtl/pipelined_alu_stream.sv
// Tagged two-operand ALU with a STAGES-deep valid/ready pipeline, global stall and synchronous flush.
// The result is computed at entry and then carried through the stages alongside its tag, op and flag.
module pipelined_alu_stream #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TAGBITS = 7,
  parameter int unsigned STAGES  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [TAGBITS-1:0] in_tag,
  input  logic [2:0]         in_op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   res,
  output logic [TAGBITS-1:0] out_tag,
  output logic [2:0]         out_op,
  output logic               out_ovf
);

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_MULT = 3'd3,
    OP_AND  = 3'd4,
    OP_OR   = 3'd5,
    OP_XOR  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  logic                 adv;
  logic                 accept;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_ovf;

  logic [STAGES-1:0]              vld_q, vld_d;
  logic [STAGES-1:0][WIDTH-1:0]   res_q, res_d;
  logic [STAGES-1:0][TAGBITS-1:0] tag_q, tag_d;
  logic [STAGES-1:0][2:0]         op_q,  op_d;
  logic [STAGES-1:0]              ovf_q, ovf_d;

  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    prod    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_e'(in_op))
      OP_ADD:  begin alu_res = sum[WIDTH-1:0];  alu_ovf = sum[WIDTH];          end
      OP_SUB:  begin alu_res = a - b;           alu_ovf = (a < b);             end
      OP_MULT: begin alu_res = prod[WIDTH-1:0]; alu_ovf = |prod[2*WIDTH-1:WIDTH]; end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      default: begin alu_res = '0; alu_ovf = 1'b0; end
    endcase
  end

  // The whole pipe moves in lockstep; a stalled output freezes every stage.
  always_comb begin
    adv      = !vld_q[STAGES-1] || out_ready;
    in_ready = adv && !flush;
    accept   = in_valid && in_ready;

    vld_d = vld_q;
    res_d = res_q;
    tag_d = tag_q;
    op_d  = op_q;
    ovf_d = ovf_q;

    if (adv) begin
      for (int unsigned i = 1; i < STAGES; i++) begin
        vld_d[i] = vld_q[i-1];
        res_d[i] = res_q[i-1];
        tag_d[i] = tag_q[i-1];
        op_d[i]  = op_q[i-1];
        ovf_d[i] = ovf_q[i-1];
      end
      vld_d[0] = accept;
      if (accept) begin
        res_d[0] = alu_res;
        tag_d[0] = in_tag;
        op_d[0]  = in_op;
        ovf_d[0] = alu_ovf;
      end
    end

    if (flush) vld_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      res_q <= '0;
      tag_q <= '0;
      op_q  <= '0;
      ovf_q <= '0;
    end else begin
      vld_q <= vld_d;
      res_q <= res_d;
      tag_q <= tag_d;
      op_q  <= op_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign res       = res_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];
  assign out_op    = op_q[STAGES-1];
  assign out_ovf   = ovf_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_alu_stream.sv
// Bench for pipelined_alu_stream: directed steps with a latency-tracking scoreboard of expected results.
module tb_pipelined_alu_stream;

  localparam int unsigned W  = 32;
  localparam int unsigned TB = 7;
  localparam int unsigned ST = 3;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [TB-1:0] in_tag, out_tag;
  logic [2:0]    in_op, out_op;
  logic [W-1:0]  a, b, res;

  pipelined_alu_stream #(.WIDTH(W), .TAGBITS(TB), .STAGES(ST)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_op(in_op),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .res(res),
    .out_tag(out_tag), .out_op(out_op), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  res;
    logic [TB-1:0] tag;
    logic [2:0]    op;
    logic          ovf;
    int unsigned   age;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   retired = 0;

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic [TB-1:0] tg);
    exp_t e;
    longint unsigned lx, ly, r;
    lx = longint'(x);
    ly = longint'(y);
    e.tag = tg; e.op = op; e.age = 1; e.res = '0; e.ovf = 1'b0;
    case (op)
      3'd1: begin r = lx + ly; e.res = r[31:0]; e.ovf = r[32]; end
      3'd2: begin e.res = x - y; e.ovf = (lx < ly); end
      3'd3: begin r = lx * ly; e.res = r[31:0]; e.ovf = (r[63:32] != 32'd0); end
      3'd4: e.res = x & y;
      3'd5: e.res = x | y;
      3'd6: e.res = x ^ y;
      default: begin e.res = '0; e.ovf = 1'b0; end
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [TB-1:0] tg, input bit ordy, input bit fl);
    in_valid = v; in_op = op; a = x; b = y; in_tag = tg; out_ready = ordy; flush = fl;
  endtask

  // One clock: check outputs at the falling edge, then update the scoreboard across the rising edge.
  task automatic step(output bit acc);
    bit   exp_ov, exp_rdy, adv;
    exp_t e;
    @(negedge clk);
    exp_ov  = (q.size() > 0) && (q[0].age == ST);
    adv     = !exp_ov || out_ready;
    exp_rdy = adv && !flush;
    chk("out_valid", 64'(out_valid), 64'(exp_ov));
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (exp_ov) begin
      chk("res", 64'(res), 64'(q[0].res));
      chk("out_tag", 64'(out_tag), 64'(q[0].tag));
      chk("out_op", 64'(out_op), 64'(q[0].op));
      chk("out_ovf", 64'(out_ovf), 64'(q[0].ovf));
    end
    acc = in_valid && exp_rdy;
    e = model(in_op, a, b, in_tag);
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else if (adv) begin
      if (exp_ov && out_ready) begin
        void'(q.pop_front());
        retired++;
      end
      for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
      if (acc) q.push_back(e);
    end
    #1;
  endtask

  initial begin
    bit acc;
    int k, r0;
    reset = 1'b0;
    drive(0, 3'd0, '0, '0, '0, 1, 0);
    #3;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_res", 64'(res), 64'd0);
    @(posedge clk); #1 reset = 1'b1;

    // Latency: single ADD emerges after three advancing cycles
    drive(1, 3'd1, 32'd5, 32'd7, 7'h11, 1, 0); step(acc);
    chk("lat_accept", 64'(acc), 64'd1);
    drive(0, 3'd0, '0, '0, '0, 1, 0);
    for (int i = 0; i < 4; i++) step(acc);
    chk("lat_retired", 64'(retired), 64'd1);

    // Arithmetic edges
    drive(1, 3'd1, 32'hFFFF_FFFF, 32'd1, 7'h21, 1, 0); step(acc);
    drive(1, 3'd2, 32'd3, 32'd5, 7'h22, 1, 0); step(acc);
    drive(1, 3'd3, 32'h1_0000, 32'h1_0000, 7'h23, 1, 0); step(acc);
    drive(1, 3'd3, 32'd6, 32'd7, 7'h24, 1, 0); step(acc);
    drive(0, 3'd0, '0, '0, '0, 1, 0);
    for (int i = 0; i < 4; i++) step(acc);
    chk("edge_drained", 64'(q.size()), 64'd0);

    // Backpressure: 10 back-to-back ops, consumer stalls for cycles 4..8
    k = 0; r0 = retired;
    for (int c = 0; c < 40; c++) begin
      drive(k < 10, 3'd1, 32'(k), 32'd100, 7'(7'h30 + k), !(c >= 4 && c <= 8), 0);
      step(acc);
      if (acc) k++;
    end
    chk("bp_accepted", 64'(k), 64'd10);
    chk("bp_retired", 64'(retired - r0), 64'd10);
    chk("bp_drained", 64'(q.size()), 64'd0);

    // Flush with three ops in flight and in_valid high
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'd6, 32'(i), 32'hF0F0, 7'(7'h40 + i), 1, 0); step(acc);
    end
    drive(1, 3'd1, 32'd1, 32'd1, 7'h4F, 0, 1); step(acc);
    chk("flush_no_accept", 64'(acc), 64'd0);
    drive(1, 3'd1, 32'd9, 32'd9, 7'h55, 1, 0); step(acc);
    chk("post_flush_accept", 64'(acc), 64'd1);
    drive(0, 3'd0, '0, '0, '0, 1, 0);
    r0 = retired;
    for (int i = 0; i < 4; i++) step(acc);
    chk("post_flush_retired", 64'(retired - r0), 64'd1);

    // Ops sweep with random operands and random consumer readiness
    r0 = retired;
    for (int i = 0; i < 48; i++) begin
      drive(1, 3'(i % 8), $urandom, (i % 8 == 3) ? 32'($urandom_range(0, 70000)) : $urandom,
            7'($urandom), 1'($urandom_range(0, 1)), 0);
      step(acc);
    end
    drive(0, 3'd0, '0, '0, '0, 1, 0);
    for (int i = 0; i < 6; i++) step(acc);
    chk("sweep_drained", 64'(q.size()), 64'd0);

    // Async reset with three ops in flight
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'd1, 32'hFFFF_FFFF, 32'(i + 1), 7'(7'h60 + i), 1, 0); step(acc);
    end
    drive(0, 3'd0, '0, '0, '0, 1, 0);
    #2 reset = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_res", 64'(res), 64'd0);
    chk("rst_ovf", 64'(out_ovf), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    q.delete();
    @(posedge clk); #2 reset = 1'b1;
    for (int i = 0; i < 5; i++) step(acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
